// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder reusing one CHUNK-bit ripple adder, LSB first.
// Optional signed-overflow flag enabled by defining ADDER_SEQ_OVF_EN.

module adder_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] s_o,
   output logic         c_o
);

   logic c;

   always_comb begin
      s_o = '0;
      c   = c_i;
      for (int i = 0; i < N; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      c_o = c;
   end

endmodule

module adder_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("adder_seq_ctrl: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic [31:0]      off;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [CHUNK-1:0] add_s;
   logic             add_co;

   // Shifting the slice down keeps the select width-clean for any CHUNK.
   assign off  = 32'(idx_q) * 32'(CHUNK);
   assign a_sh = a_q >> off;
   assign b_sh = b_q >> off;

   adder_n #(.N(CHUNK)) u_add (
      .a_i (a_sh[CHUNK-1:0]),
      .b_i (b_sh[CHUNK-1:0]),
      .c_i (carry_q),
      .s_o (add_s),
      .c_o (add_co)
   );

`ifdef ADDER_SEQ_OVF_EN
   logic ovf_q, ovf_d;
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef ADDER_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef ADDER_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = c_in;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = (sum_q & ~(MASK << off))
                    | (WIDTH'(add_s) << off);
            carry_d = add_co;
            if (idx_q == LAST) begin
               state_d = DONE;
               cout_d  = add_co;
`ifdef ADDER_SEQ_OVF_EN
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                       && (add_s[CHUNK-1] != a_q[WIDTH-1]);
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
`ifdef ADDER_SEQ_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign c_out     = cout_q;

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit addition using one shared CHUNK-bit ripple-carry adder_n instance over WIDTH/CHUNK cycles.
- Chunks are processed LSB first; the carry between chunks is held in a register.
- Valid/ready handshake on input and output.
- Used in the FIR datapath to trade adder area for latency on wide accumulations.

Parameters:
WIDTH, 32, operand and result width in bits.
CHUNK, 8, width of the shared adder_n instance (its N). WIDTH % CHUNK must be 0; otherwise elaboration fails with $error.
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry into bit 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
c_out  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, ovf=0, chunk counter=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b into operand regs; carry reg<=c_in; idx<=0; go to RUN.
- RUN:
  - in_ready=0. Inputs a, b, c_in are ignored.
  - Adder inputs: a_reg[idx*CHUNK +: CHUNK], b_reg[same slice], carry reg.
  - Each edge: result slice idx <= adder sum; carry reg <= adder c_out; idx<=idx+1.
  - When idx==NCHUNK-1 at the edge: go to DONE; c_out<=adder c_out.
- DONE:
  - out_valid=1. sum and c_out are held stable.
  - Edge with out_ready=1: go to IDLE, out_valid<=0.
  - in_ready stays 0 in DONE; there is no same-cycle turnaround.
- Latency: operands accepted at edge E0; out_valid is high after edge E_NCHUNK (NCHUNK cycles). Throughput is one operation per NCHUNK+2 cycles minimum.
- sum is a register. It is updated chunk by chunk during RUN and is valid only when out_valid=1. A new operation clears no bits; each chunk is overwritten.
- idx is $clog2(NCHUNK)-bit wide, minimum 1 bit. It never wraps past NCHUNK-1.
- NCHUNK==1 (CHUNK==WIDTH): a single RUN cycle, so latency is 1.
- Arithmetic is unsigned modulo 2^WIDTH. The carry out of the top bit appears on c_out only.
- Reset in any state: on the next edge return to IDLE with all reset values. Any in-flight operation is discarded and the result is never presented.
- out_ready while not in DONE: ignored.
- in_valid while not in IDLE: ignored; the upstream holds the operands until in_ready.

Optional Feature:
Macro ADDER_SEQ_OVF_EN.
- Defined:
  - On the final RUN edge, ovf <= signed overflow of the full add: (a_reg[MSB]==b_reg[MSB]) && (adder sum MSB != a_reg[MSB]).
  - Held through DONE; cleared on reset or when leaving DONE.
- Undefined: ovf is tied to 0 and no overflow logic is built. The port list is identical in both cases.

Test Plan:
1. WIDTH=32, CHUNK=8. a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1; out_valid rises exactly 4 cycles after the accept edge.
2. a=0x12345678, b=0x11111111, c_in=1 -> sum=0x2345678A, c_out=0. Change a/b on the inputs during RUN; the result is unchanged.
3. Backpressure: complete any add, hold out_ready=0 for 5 cycles -> out_valid=1, sum/c_out stable, in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle, in_ready=1.
4. Reset mid-op: assert rst for 1 cycle during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, busy=0. A following add 0x00000005+0x00000003 gives sum=0x00000008.
5. With ADDER_SEQ_OVF_EN: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, c_out=0. Without the macro: same sum, ovf=0.
6. WIDTH=16, CHUNK=16: a=0x8000, b=0x8000, c_in=1 -> sum=0x0001, c_out=1, out_valid 1 cycle after accept.
